per2axi_req_buffer: RTL and testbench
=====================================

Name: per2axi_req_buffer

Overview:
- Registered, parametrised request stage between the peripheral interconnect slave port and an AXI4 master (AW/W/AR channels).
- Generalises the combinational request path in three ways: any AXI data width of 32 or more, fully AXI-compliant held valids with independent AW/W completion, and per-direction outstanding-transaction limits fed back from the response channel.

Parameters:
- NB_CORES, 4, number of cores; size of the axuser table
- PER_ADDR_WIDTH, 32, peripheral address width
- PER_ID_WIDTH, 5, one-hot peripheral ID width
- AXI_ADDR_WIDTH, 32, AXI address width (must equal PER_ADDR_WIDTH)
- AXI_DATA_WIDTH, 64, AXI data width; power of two, 32 or more
- AXI_USER_WIDTH, 6, AXI user width
- AXI_ID_WIDTH, 3, AXI ID width; must satisfy 2^AXI_ID_WIDTH >= PER_ID_WIDTH
- MAX_OUTSTANDING, 4, maximum in-flight reads and, separately, maximum in-flight writes; 1 or more
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, derived; do not override

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- per_slave_req_i  in  1  request
- per_slave_add_i  in  PER_ADDR_WIDTH  byte address
- per_slave_we_i  in  1  0 = write, 1 = read (interconnect convention)
- per_slave_atop_i  in  6  atomic opcode (riscv_defines encodings)
- per_slave_wdata_i  in  32  write data
- per_slave_be_i  in  4  byte enables
- per_slave_id_i  in  PER_ID_WIDTH  one-hot requester ID
- per_slave_gnt_o  out  1  grant
- axi_axuser_i  in  NB_CORES*AXI_USER_WIDTH  per-core user field
- axi_master_aw_*  out  (valid, addr, prot, region, len, size, burst, lock, cache, qos, id, user), plus axi_master_aw_ready_i in
- axi_master_w_*  out  (valid, data, strb, user, last), plus axi_master_w_ready_i in
- axi_master_ar_*  out  (valid, addr, prot, region, len, size, burst, lock, cache, qos, id, user), plus axi_master_ar_ready_i in
- trans_r_done_i  in  1  one read response retired (R beat with last)
- trans_b_done_i  in  1  one write response retired (B handshake)
- trans_req_o  out  1  pulse on AR handshake
- trans_id_o  out  AXI_ID_WIDTH  ID of that AR
- trans_add_o  out  AXI_ADDR_WIDTH  address of that AR

Behaviour:
- States: IDLE, RD (AR pending), WR (AW and/or W pending). Reset state is IDLE; all registers and valids are 0; rd_cnt = wr_cnt = 0.
- Grant: per_slave_gnt_o = (state == IDLE) && (we ? rd_cnt < MAX_OUTSTANDING : wr_cnt < MAX_OUTSTANDING). It is combinational and independent of any AXI ready.
- Capture: on req && gnt, capture the request into the payload register.
  - Read: go to RD.
  - Write: go to WR and set aw_pend = w_pend = 1.
- Latency: valids assert in the cycle after the grant. The minimum gap between grants is 2 cycles.
- RD: ar_valid = 1 until ar_ready, then return to IDLE. trans_req_o, trans_id_o and trans_add_o are asserted combinationally in the handshake cycle.
- WR: aw_valid = aw_pend and w_valid = w_pend.
  - Each flag clears on its own handshake.
  - Return to IDLE when both flags are clear; both handshakes may occur in the same cycle.
  - w_last = w_valid.
- Valid stability: once asserted, a valid and its payload stay constant until the handshake. A valid never depends on a ready.
- Data lane: lane = add[log2(AXI_STRB_WIDTH)-1 : 2] (0 when AXI_DATA_WIDTH == 32). wdata is placed at bits [32*lane +: 32]; be at strb bits [4*lane +: 4]; all other bits are 0.
- Size from be:
  - single bit set -> 0
  - 0011, 0110 or 1100 -> 1
  - 1111 -> 2
  - any other value -> 2
- ID: binary index of the highest set bit of per_slave_id_i; 0 if none is set. aw_user and ar_user = axi_axuser_i[id].
- Lock: atop == AMO_LR on a read -> ar_lock = 1; atop == AMO_SC on a write -> aw_lock = 1; otherwise 0.
- Fixed fields: burst = FIXED (00), len = 0. prot, region, cache, qos and w_user are 0.
- rd_cnt:
  - +1 on AR handshake, -1 on trans_r_done_i; both in the same cycle -> unchanged.
  - A done pulse with the count at 0 is ignored (saturates, no underflow).
- wr_cnt: same rules, incremented on AW handshake and decremented on trans_b_done_i.
- Reset mid-transaction: state, flags and counters clear immediately and valids drop. No recovery of the lost transaction.

Test Plan:
- Read: read req (add 0x1000_0004, be 1111, id 00100) -> gnt 1; next cycle ar_valid, addr 0x1000_0004, id 2, size 2. Hold ar_ready low 3 cycles -> ar_valid and payload stable; trans_req_o pulses in the handshake cycle only.
- Independent AW/W completion, DW=64: write req (add 0x8, wdata 0xDEADBEEF, be 0011) -> w_data 0x0000_0000_DEADBEEF, strb 0x03, size 1. Raise aw_ready 2 cycles before w_ready -> aw_valid drops first; return to IDLE only after the W handshake.
- Upper lane and ID decode, DW=128: write to add 0xC with be 0100 -> strb bit 14 only, size 0; with id 10001 -> AXI ID 4.
- Outstanding limit, MAX_OUTSTANDING=2: complete 2 ARs without trans_r_done_i -> third read gnt = 0 while a write is still granted. Pulse trans_r_done_i -> read gnt returns. Simultaneous AR handshake and done -> rd_cnt unchanged.
- Atomics: atop AMO_LR on a read -> ar_lock 1; atop AMO_SC on a write -> aw_lock 1; any other atop -> both 0.
- Reset mid-WR: assert rst_ni low while aw_valid = 1 -> all valids 0 asynchronously and counters 0; gnt = 1 on the first cycle after release.

Source files
------------

// File: rtl/per2axi_req_buffer.sv
// Purpose : registered request stage from the peripheral slave port onto AXI4 AW/W/AR.
// Latency : AXI valids assert the cycle after the grant; next grant no earlier than 2 cycles later.
// Backpress: grant only in IDLE and below the per-direction outstanding limit; valids are held
//            with stable payload until their own handshake and never depend on a ready.
// Ports   : per_slave_* request/grant in, axi_axuser_i per-core user table,
//           axi_master_{aw,w,ar}_* AXI channels, trans_{r,b}_done_i response retire pulses,
//           trans_{req,id,add}_o report of each AR handshake to the response side.
module per2axi_req_buffer #(
  parameter int NB_CORES        = 4,
  parameter int PER_ADDR_WIDTH  = 32,
  parameter int PER_ID_WIDTH    = 5,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int AXI_ID_WIDTH    = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH/8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,

  input  logic                             per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0]        per_slave_add_i,
  input  logic                             per_slave_we_i,
  input  logic [5:0]                       per_slave_atop_i,
  input  logic [31:0]                      per_slave_wdata_i,
  input  logic [3:0]                       per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]          per_slave_id_i,
  output logic                             per_slave_gnt_o,

  input  logic [NB_CORES*AXI_USER_WIDTH-1:0] axi_axuser_i,

  output logic                             axi_master_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]        axi_master_aw_addr_o,
  output logic [2:0]                       axi_master_aw_prot_o,
  output logic [3:0]                       axi_master_aw_region_o,
  output logic [7:0]                       axi_master_aw_len_o,
  output logic [2:0]                       axi_master_aw_size_o,
  output logic [1:0]                       axi_master_aw_burst_o,
  output logic                             axi_master_aw_lock_o,
  output logic [3:0]                       axi_master_aw_cache_o,
  output logic [3:0]                       axi_master_aw_qos_o,
  output logic [AXI_ID_WIDTH-1:0]          axi_master_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]        axi_master_aw_user_o,
  input  logic                             axi_master_aw_ready_i,

  output logic                             axi_master_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]        axi_master_w_data_o,
  output logic [AXI_STRB_WIDTH-1:0]        axi_master_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0]        axi_master_w_user_o,
  output logic                             axi_master_w_last_o,
  input  logic                             axi_master_w_ready_i,

  output logic                             axi_master_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]        axi_master_ar_addr_o,
  output logic [2:0]                       axi_master_ar_prot_o,
  output logic [3:0]                       axi_master_ar_region_o,
  output logic [7:0]                       axi_master_ar_len_o,
  output logic [2:0]                       axi_master_ar_size_o,
  output logic [1:0]                       axi_master_ar_burst_o,
  output logic                             axi_master_ar_lock_o,
  output logic [3:0]                       axi_master_ar_cache_o,
  output logic [3:0]                       axi_master_ar_qos_o,
  output logic [AXI_ID_WIDTH-1:0]          axi_master_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]        axi_master_ar_user_o,
  input  logic                             axi_master_ar_ready_i,

  input  logic                             trans_r_done_i,
  input  logic                             trans_b_done_i,
  output logic                             trans_req_o,
  output logic [AXI_ID_WIDTH-1:0]          trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]        trans_add_o
);

  // riscv_defines atomic opcodes that map onto AXI exclusive access
  localparam logic [5:0] AMO_LR = 6'h02;
  localparam logic [5:0] AMO_SC = 6'h03;

  localparam int OFF_W  = $clog2(AXI_STRB_WIDTH);
  localparam int LANE_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                      state;
  logic                        aw_pend, w_pend;
  logic [CNT_W-1:0]            rd_cnt, wr_cnt;

  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]                  size_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [AXI_USER_WIDTH-1:0]   user_q;
  logic                        lock_q;
  logic [AXI_DATA_WIDTH-1:0]   data_q;
  logic [AXI_STRB_WIDTH-1:0]   strb_q;

  logic [LANE_W-1:0]           lane;
  logic [AXI_DATA_WIDTH-1:0]   data_dec;
  logic [AXI_STRB_WIDTH-1:0]   strb_dec;
  logic [2:0]                  size_dec;
  logic [AXI_ID_WIDTH-1:0]     id_dec;
  logic [AXI_USER_WIDTH-1:0]   user_dec;
  logic                        lock_dec;

  logic                        ar_hs, aw_hs, w_hs, rd_dec, wr_dec, req_hs;

  // 32-bit lane inside the AXI data word; a 32-bit bus has a single lane
  generate
    if (OFF_W > 2) begin : g_lane
      assign lane = per_slave_add_i[OFF_W-1:2];
    end else begin : g_nolane
      assign lane = '0;
    end
  endgenerate

  always_comb begin
    data_dec = '0;
    strb_dec = '0;
    data_dec[32*lane +: 32] = per_slave_wdata_i;
    strb_dec[4*lane +: 4]   = per_slave_be_i;
  end

  always_comb begin
    case (per_slave_be_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_dec = 3'd0;
      4'b0011, 4'b0110, 4'b1100:          size_dec = 3'd1;
      default:                            size_dec = 3'd2;
    endcase
  end

  // Highest set bit of the one-hot requester ID wins; later iterations override
  always_comb begin
    id_dec = '0;
    for (int i = 0; i < PER_ID_WIDTH; i++) begin
      if (per_slave_id_i[i]) id_dec = AXI_ID_WIDTH'(i);
    end
  end

  // IDs beyond the core table (e.g. a non-core requester) get a zero user field
  always_comb begin
    user_dec = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (32'(id_dec) == i) user_dec = axi_axuser_i[i*AXI_USER_WIDTH +: AXI_USER_WIDTH];
    end
  end

  assign lock_dec = per_slave_we_i ? (per_slave_atop_i == AMO_LR)
                                   : (per_slave_atop_i == AMO_SC);

  assign per_slave_gnt_o = (state == IDLE) &&
                           (per_slave_we_i ? (rd_cnt < MAX_CNT) : (wr_cnt < MAX_CNT));
  assign req_hs = per_slave_req_i && per_slave_gnt_o;

  assign axi_master_ar_valid_o = (state == RD);
  assign axi_master_aw_valid_o = (state == WR) && aw_pend;
  assign axi_master_w_valid_o  = (state == WR) && w_pend;

  assign ar_hs = axi_master_ar_valid_o && axi_master_ar_ready_i;
  assign aw_hs = axi_master_aw_valid_o && axi_master_aw_ready_i;
  assign w_hs  = axi_master_w_valid_o  && axi_master_w_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      id_q    <= '0;
      user_q  <= '0;
      lock_q  <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            addr_q <= per_slave_add_i;
            size_q <= size_dec;
            id_q   <= id_dec;
            user_q <= user_dec;
            lock_q <= lock_dec;
            data_q <= data_dec;
            strb_q <= strb_dec;
            if (per_slave_we_i) begin
              state <= RD;
            end else begin
              state   <= WR;
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
            end
          end
        end
        RD: begin
          if (ar_hs) state <= IDLE;
        end
        WR: begin
          if (aw_hs) aw_pend <= 1'b0;
          if (w_hs)  w_pend  <= 1'b0;
          // leave once each channel is either already done or completing now
          if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Retire pulses arriving with an empty count are dropped rather than wrapping
  assign rd_dec = trans_r_done_i && (rd_cnt != '0);
  assign wr_dec = trans_b_done_i && (wr_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (ar_hs && !rd_dec)      rd_cnt <= rd_cnt + 1'b1;
      else if (!ar_hs && rd_dec) rd_cnt <= rd_cnt - 1'b1;
      if (aw_hs && !wr_dec)      wr_cnt <= wr_cnt + 1'b1;
      else if (!aw_hs && wr_dec) wr_cnt <= wr_cnt - 1'b1;
    end
  end

  assign axi_master_aw_addr_o   = addr_q;
  assign axi_master_aw_prot_o   = '0;
  assign axi_master_aw_region_o = '0;
  assign axi_master_aw_len_o    = '0;
  assign axi_master_aw_size_o   = size_q;
  assign axi_master_aw_burst_o  = 2'b00;
  assign axi_master_aw_lock_o   = lock_q;
  assign axi_master_aw_cache_o  = '0;
  assign axi_master_aw_qos_o    = '0;
  assign axi_master_aw_id_o     = id_q;
  assign axi_master_aw_user_o   = user_q;

  assign axi_master_w_data_o    = data_q;
  assign axi_master_w_strb_o    = strb_q;
  assign axi_master_w_user_o    = '0;
  assign axi_master_w_last_o    = axi_master_w_valid_o;

  assign axi_master_ar_addr_o   = addr_q;
  assign axi_master_ar_prot_o   = '0;
  assign axi_master_ar_region_o = '0;
  assign axi_master_ar_len_o    = '0;
  assign axi_master_ar_size_o   = size_q;
  assign axi_master_ar_burst_o  = 2'b00;
  assign axi_master_ar_lock_o   = lock_q;
  assign axi_master_ar_cache_o  = '0;
  assign axi_master_ar_qos_o    = '0;
  assign axi_master_ar_id_o     = id_q;
  assign axi_master_ar_user_o   = user_q;

  assign trans_req_o = ar_hs;
  assign trans_id_o  = id_q;
  assign trans_add_o = addr_q;

endmodule

// File: tb/tb_per2axi_req_buffer.sv
// Bench for per2axi_req_buffer built with a 128-bit data bus and an outstanding limit of 2.
module tb_per2axi_req_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 0, we = 0;
  logic [31:0] add = 0, wdata = 0;
  logic [5:0]  atop = 0;
  logic [3:0]  be = 0;
  logic [4:0]  pid = 0;
  logic        gnt;
  logic [23:0] axuser = {6'd44, 6'd33, 6'd22, 6'd11};

  logic        aw_valid, aw_lock, aw_ready = 1;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot, aw_size, aw_id;
  logic [3:0]  aw_region, aw_cache, aw_qos;
  logic [7:0]  aw_len;
  logic [1:0]  aw_burst;
  logic [5:0]  aw_user;

  logic         w_valid, w_last, w_ready = 1;
  logic [127:0] w_data;
  logic [15:0]  w_strb;
  logic [5:0]   w_user;

  logic        ar_valid, ar_lock, ar_ready = 1;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot, ar_size, ar_id;
  logic [3:0]  ar_region, ar_cache, ar_qos;
  logic [7:0]  ar_len;
  logic [1:0]  ar_burst;
  logic [5:0]  ar_user;

  logic        r_done = 0, b_done = 0;
  logic        t_req;
  logic [2:0]  t_id;
  logic [31:0] t_add;

  per2axi_req_buffer #(
    .NB_CORES(4), .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(128), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(3), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
    .per_slave_atop_i(atop), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_id_i(pid), .per_slave_gnt_o(gnt),
    .axi_axuser_i(axuser),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
    .axi_master_aw_prot_o(aw_prot), .axi_master_aw_region_o(aw_region),
    .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
    .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
    .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
    .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
    .axi_master_aw_ready_i(aw_ready),
    .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
    .axi_master_w_strb_o(w_strb), .axi_master_w_user_o(w_user),
    .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
    .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
    .axi_master_ar_len_o(ar_len), .axi_master_ar_size_o(ar_size),
    .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
    .axi_master_ar_cache_o(ar_cache), .axi_master_ar_qos_o(ar_qos),
    .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
    .axi_master_ar_ready_i(ar_ready),
    .trans_r_done_i(r_done), .trans_b_done_i(b_done),
    .trans_req_o(t_req), .trans_id_o(t_id), .trans_add_o(t_add)
  );

  typedef struct {
    logic         we;
    logic [31:0]  add;
    logic [5:0]   atop;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic [4:0]   id;
    logic [2:0]   e_id;
    logic [2:0]   e_size;
    logic         e_lock;
    logic [5:0]   e_user;
    logic [15:0]  e_strb;
    logic [127:0] e_data;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [2:0]   id;
    logic [2:0]   size;
    logic         lock;
    logic [5:0]   user;
    logic [15:0]  strb;
    logic [127:0] data;
  } exp_t;

  exp_t rd_q[$], aw_q[$], w_q[$];
  vec_t tbl [8];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: pop the expected payload at every channel handshake
  always @(negedge clk) begin
    exp_t e;
    if (ar_valid && ar_ready) begin
      if (rd_q.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("ar_addr", ar_addr, e.addr);
        chk("ar_id", ar_id, e.id);
        chk("ar_size", ar_size, e.size);
        chk("ar_lock", ar_lock, e.lock);
        chk("ar_user", ar_user, e.user);
        chk("ar_fixed", {ar_len, ar_burst, ar_prot, ar_region, ar_cache, ar_qos}, 0);
        chk("trans_req", t_req, 1);
        chk("trans_id", t_id, e.id);
        chk("trans_add", t_add, e.addr);
      end
    end
    if (aw_valid && aw_ready) begin
      if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        e = aw_q.pop_front();
        chk("aw_addr", aw_addr, e.addr);
        chk("aw_id", aw_id, e.id);
        chk("aw_size", aw_size, e.size);
        chk("aw_lock", aw_lock, e.lock);
        chk("aw_user", aw_user, e.user);
        chk("aw_fixed", {aw_len, aw_burst, aw_prot, aw_region, aw_cache, aw_qos}, 0);
      end
    end
    if (w_valid && w_ready) begin
      if (w_q.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        e = w_q.pop_front();
        chk("w_data", w_data, e.data);
        chk("w_strb", w_strb, e.strb);
        chk("w_last", w_last, 1);
        chk("w_user", w_user, 0);
      end
    end
  end

  // One-cycle request; expectation is queued as the request is driven
  task automatic issue(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    req = 1; we = v.we; add = v.add; atop = v.atop; wdata = v.wdata; be = v.be; pid = v.id;
    #1;
    chk("issue_gnt", gnt, 1);
    e.addr = v.add; e.id = v.e_id; e.size = v.e_size; e.lock = v.e_lock;
    e.user = v.e_user; e.strb = v.e_strb; e.data = v.e_data;
    if (v.we) rd_q.push_back(e);
    else begin
      aw_q.push_back(e);
      w_q.push_back(e);
    end
    @(posedge clk); #1;
    req = 0;
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ar_valid || aw_valid || w_valid) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_timeout", (n < 20), 1);
  endtask

  task automatic pulse_done(input logic r, input logic b);
    @(posedge clk); #1;
    r_done = r; b_done = b;
    @(posedge clk); #1;
    r_done = 0; b_done = 0;
  endtask

  task automatic gnt_for(input logic dir, input logic exp, input string name);
    @(posedge clk); #1;
    req = 0; we = dir;
    #1;
    chk(name, gnt, exp);
  endtask

  initial begin
    //          we  add           atop   wdata         be       id        eid   esz   lk  usr    strb      data
    tbl[0] = '{1'b1, 32'h1000_0004, 6'h00, 32'h0,        4'b1111, 5'b00100, 3'd2, 3'd2, 1'b0, 6'd33, 16'h0,    128'h0};
    tbl[1] = '{1'b0, 32'h0000_0008, 6'h00, 32'hDEADBEEF, 4'b0011, 5'b00001, 3'd0, 3'd1, 1'b0, 6'd11, 16'h0300,
               128'h00000000_DEADBEEF_00000000_00000000};
    tbl[2] = '{1'b0, 32'h0000_000C, 6'h00, 32'h12345678, 4'b0100, 5'b10001, 3'd4, 3'd0, 1'b0, 6'd0,  16'h4000,
               128'h12345678_00000000_00000000_00000000};
    tbl[3] = '{1'b1, 32'h0000_0020, 6'h02, 32'h0,        4'b1111, 5'b00010, 3'd1, 3'd2, 1'b1, 6'd22, 16'h0,    128'h0};
    tbl[4] = '{1'b0, 32'h0000_0024, 6'h03, 32'hCAFEF00D, 4'b1111, 5'b01000, 3'd3, 3'd2, 1'b1, 6'd44, 16'h00F0,
               128'h00000000_00000000_CAFEF00D_00000000};
    tbl[5] = '{1'b1, 32'h0000_0030, 6'h03, 32'h0,        4'b0110, 5'b00000, 3'd0, 3'd1, 1'b0, 6'd11, 16'h0,    128'h0};
    tbl[6] = '{1'b0, 32'h0000_003C, 6'h02, 32'hA5A55A5A, 4'b1010, 5'b00000, 3'd0, 3'd2, 1'b0, 6'd11, 16'hA000,
               128'hA5A55A5A_00000000_00000000_00000000};
    tbl[7] = '{1'b0, 32'h0000_0000, 6'h0B, 32'h11223344, 4'b1000, 5'b00011, 3'd1, 3'd0, 1'b0, 6'd22, 16'h0008,
               128'h00000000_00000000_00000000_11223344};

    // reset state
    #12;
    chk("rst_valids", {ar_valid, aw_valid, w_valid}, 0);
    chk("rst_trans_req", t_req, 0);
    @(posedge clk); #1;
    rst_n = 1;
    gnt_for(1'b1, 1'b1, "rst_gnt_rd");
    gnt_for(1'b0, 1'b1, "rst_gnt_wr");

    // table: every vector with readies held high
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i]);
      wait_idle();
      pulse_done(tbl[i].we, !tbl[i].we);
    end

    // AR held while ready is low
    ar_ready = 0;
    issue(tbl[0]);
    for (int k = 0; k < 3; k++) begin
      chk("stall_ar_valid", ar_valid, 1);
      chk("stall_ar_addr", ar_addr, 32'h1000_0004);
      chk("stall_ar_id", ar_id, 3'd2);
      chk("stall_trans_req", t_req, 0);
      @(posedge clk); #2;
    end
    ar_ready = 1;
    #1;
    chk("hs_trans_req", t_req, 1);
    @(posedge clk); #2;
    chk("post_ar_valid", ar_valid, 0);
    chk("post_trans_req", t_req, 0);
    pulse_done(1'b1, 1'b0);

    // AW completes two cycles before W
    aw_ready = 0; w_ready = 0;
    issue(tbl[1]);
    chk("wr_both_valid", {aw_valid, w_valid}, 2'b11);
    aw_ready = 1;
    @(posedge clk); #1;
    aw_ready = 0;
    #1;
    chk("aw_first_valids", {aw_valid, w_valid}, 2'b01);
    chk("aw_first_gnt", gnt, 0);
    @(posedge clk); #2;
    chk("w_hold_valid", w_valid, 1);
    chk("w_hold_gnt", gnt, 0);
    w_ready = 1;
    @(posedge clk); #2;
    chk("w_done_valid", w_valid, 0);
    chk("w_done_gnt", gnt, 1);
    aw_ready = 1;
    pulse_done(1'b0, 1'b1);

    // outstanding read limit of 2
    issue(tbl[0]); wait_idle();
    issue(tbl[3]); wait_idle();
    gnt_for(1'b1, 1'b0, "lim_rd_blocked");
    issue(tbl[1]); wait_idle();          // write still granted
    pulse_done(1'b0, 1'b1);
    pulse_done(1'b1, 1'b0);
    gnt_for(1'b1, 1'b1, "lim_rd_back");
    issue(tbl[5]);                       // AR handshake lands with a retire
    r_done = 1;
    @(posedge clk); #1;
    r_done = 0;
    wait_idle();
    issue(tbl[0]); wait_idle();          // count 1 -> 2
    gnt_for(1'b1, 1'b0, "lim_simul_unchanged");
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b1, 1'b0);              // extra retire at zero is dropped
    issue(tbl[3]); wait_idle();
    issue(tbl[5]); wait_idle();
    gnt_for(1'b1, 1'b0, "lim_after_saturate");

    // reset in the middle of a write with two reads outstanding
    aw_ready = 0; w_ready = 0;
    issue(tbl[4]);
    chk("mid_wr_aw_valid", aw_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_valids", {ar_valid, aw_valid, w_valid}, 0);
    rd_q.delete(); aw_q.delete(); w_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    aw_ready = 1; w_ready = 1;
    we = 1;
    #1;
    chk("arst_gnt_rd", gnt, 1);
    issue(tbl[3]); wait_idle();
    issue(tbl[7]); wait_idle();

    chk("rd_q_empty", rd_q.size(), 0);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
